aes_key_expand: RTL

- Iterative AES-128 key schedule (FIPS-197) that turns one 128-bit cipher key into the 11 round keys, rounds 0..10.
- Emits one round key per valid/ready handshake, in round order.
- Sits directly upstream of the AddRoundKey stage and drives its key operand.
- Computes each next round key from the current one, so no key storage beyond one 128-bit register is needed.

---
 rtl/aes_key_expand.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES-128 key schedule emitting round keys 0..10 over a valid/ready handshake
//
// aes_sbox: FIPS-197 forward S-box, purely combinational.
//   in_i   [7:0]  input byte
//   out_o  [7:0]  substituted byte
//
// aes_key_expand: expands one 128-bit cipher key into 11 round keys, one per
// accepted handshake, recomputing each key from the previous one in place.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      expand key_in (sampled only while idle)
//   key_in     cipher key, byte 0 in [127:120]
//   rk_ready   downstream accepts round_key this cycle
//   round_key  current round key (same byte order as key_in)
//   round_idx  round index of round_key, 0..10
//   rk_valid   round_key/round_idx valid
//   busy       expansion in progress
//   done       one-cycle pulse after round 10 is accepted

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Row 0 of the table sits in the top bits, so byte x lives at offset 255-x.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_base;

  // ~in_i == 255 - in_i; times 8 gives the bit offset of the entry.
  assign bit_base = {~in_i, 3'b000};
  assign out_o    = SBOX_TABLE[bit_base +: 8];

endmodule

module aes_key_expand #(
  parameter int NUM_ROUNDS = 10,
  parameter int RND_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [127:0]     key_in,
  input  logic             rk_ready,
  output logic [127:0]     round_key,
  output logic [RND_W-1:0] round_idx,
  output logic             rk_valid,
  output logic             busy,
  output logic             done
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_key_expand: only NUM_ROUNDS = 10 (AES-128) is supported");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [RND_W-1:0] LAST_IDX = RND_W'(NUM_ROUNDS);

  state_t           state_q;
  logic [127:0]     round_key_q;
  logic [127:0]     round_key_d;
  logic [RND_W-1:0] round_idx_q;
  logic [7:0]       rcon_q;
  logic [7:0]       rcon_d;
  logic             rk_valid_q;
  logic             busy_q;
  logic             done_q;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3;
  logic [31:0] sub_w3;
  logic [31:0] temp_w;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = round_key_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot_w3[8*b +: 8]),
      .out_o (sub_w3[8*b +: 8])
    );
  end

  assign temp_w = sub_w3 ^ {rcon_q, 24'h000000};
  assign n0     = w0 ^ temp_w;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;

  assign round_key_d = {n0, n1, n2, n3};
  // xtime: multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  assign rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      round_idx_q <= '0;
      rcon_q      <= 8'h01;
      rk_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            round_key_q <= key_in;
            round_idx_q <= '0;
            rcon_q      <= 8'h01;
            rk_valid_q  <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (rk_valid_q && rk_ready) begin
            if (round_idx_q == LAST_IDX) begin
              // Last key delivered; key and index hold their final values.
              state_q    <= IDLE;
              rk_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              round_key_q <= round_key_d;
              round_idx_q <= round_idx_q + 1'b1;
              rcon_q      <= rcon_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign round_key = round_key_q;
  assign round_idx = round_idx_q;
  assign rk_valid  = rk_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
